// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard that interlocks ID-stage consumers against in-flight producers.
// Latency: stall is combinational from ID inputs and current counters; busy/stall_cycles follow the registered table.
// Backpressure: stall holds PC/IF-ID and bubbles ID/EX; a stalled or flushed instruction never writes the table.
//
// Ports:
//   clk, rst_n            - rising-edge clock, asynchronous active-low reset
//   id_valid, id_flush    - ID holds a real instruction / squash it this cycle
//   id_rs, id_rt          - source indices, qualified by id_use_rs / id_use_rt
//   id_branch             - consumer compares in ID (needs distance-0 operand when BR_IN_ID)
//   id_wr_en, id_wreg     - destination write enable / index
//   id_lat                - cycles until the produced value is forwardable (clamped to MAX_LAT)
//   stall                 - hold request for the ID instruction
//   busy                  - bit i set while register i still has a pending count
//   stall_cycles          - saturating count of stalled cycles
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int MAX_LAT  = 3,
    parameter int LW       = 2,
    parameter int BR_IN_ID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_branch,
    input  logic            id_wr_en,
    input  logic [AW-1:0]   id_wreg,
    input  logic [LW-1:0]   id_lat,
    input  logic            id_flush,
    output logic            stall,
    output logic [NREG-1:0] busy,
    output logic [31:0]     stall_cycles
);

    localparam logic [LW-1:0] MAX_LAT_C = LW'(MAX_LAT);

    logic [LW-1:0] cnt_q [NREG];
    logic [LW-1:0] cnt_d [NREG];
    logic [31:0]   stall_cycles_q;
    logic [31:0]   stall_cycles_d;

    logic [LW-1:0] thr;
    logic [LW-1:0] lat_eff;
    logic          hz_rs;
    logic          hz_rt;
    logic          issue;

    // Branches resolving in ID cannot take the EX->EX bypass, so they need
    // the count fully drained; everything else tolerates one outstanding cycle.
    always_comb begin
        thr = LW'(1);
        if ((BR_IN_ID != 0) && id_branch) begin
            thr = '0;
        end
    end

    always_comb begin
        lat_eff = id_lat;
        if (id_lat > MAX_LAT_C) begin
            lat_eff = MAX_LAT_C;
        end
    end

    // Hazards look at the old counts, so an instruction that both reads and
    // writes the same register is judged against the earlier producer.
    always_comb begin
        hz_rs = id_use_rs && (id_rs != '0) && (cnt_q[id_rs] > thr);
        hz_rt = id_use_rt && (id_rt != '0) && (cnt_q[id_rt] > thr);
        stall = id_valid && !id_flush && (hz_rs || hz_rt);
        issue = id_valid && !id_flush && !stall;
    end

    always_comb begin
        cnt_d[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            if (issue && id_wr_en && (id_wreg == AW'(i))) begin
                // Newest producer owns the register regardless of the old count.
                cnt_d[i] = lat_eff;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - LW'(1);
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        busy[0] = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (branch-in-ID and branch-in-EX) share stimulus.
// Reference model keeps, per register, the absolute cycle at which its value becomes fully drained.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_branch;
    logic        id_wr_en;
    logic [4:0]  id_wreg;
    logic [1:0]  id_lat;
    logic        id_flush;

    logic        stall0, stall1;
    logic [31:0] busy0, busy1;
    logic [31:0] sc0, sc1;

    hazard_scoreboard #(.NREG(32), .AW(5), .MAX_LAT(3), .LW(2), .BR_IN_ID(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_wr_en(id_wr_en), .id_wreg(id_wreg), .id_lat(id_lat), .id_flush(id_flush),
        .stall(stall0), .busy(busy0), .stall_cycles(sc0)
    );

    hazard_scoreboard #(.NREG(32), .AW(5), .MAX_LAT(3), .LW(2), .BR_IN_ID(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_wr_en(id_wr_en), .id_wreg(id_wreg), .id_lat(id_lat), .id_flush(id_flush),
        .stall(stall1), .busy(busy1), .stall_cycles(sc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic       we;
        logic [4:0] wr;
        logic [1:0] lat;
        logic       fl;
    } stim_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model state: done[k][r] = cycle at which register r's count reaches zero.
    longint done [2][32];
    longint scnt [2];
    longint cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic stim_t mk(input int rst, input int v, input int rs, input int rt,
                                 input int urs, input int urt, input int br, input int we,
                                 input int wr, input int lat, input int fl);
        stim_t s;
        s.rst_n = 1'(rst);
        s.v     = 1'(v);
        s.rs    = 5'(rs);
        s.rt    = 5'(rt);
        s.urs   = 1'(urs);
        s.urt   = 1'(urt);
        s.br    = 1'(br);
        s.we    = 1'(we);
        s.wr    = 5'(wr);
        s.lat   = 2'(lat);
        s.fl    = 1'(fl);
        return s;
    endfunction

    function automatic stim_t nop();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic bit model_hz(input int k, input logic use_r, input logic [4:0] r, input int thr);
        return use_r && (r != 5'd0) && ((done[k][r] - cyc) > thr);
    endfunction

    // Compares both instances against the model for the current cycle, then
    // advances the model across the coming rising edge.
    task automatic compare_and_advance();
        bit     exp_stall [2];
        logic [31:0] exp_busy;
        int     thr;
        int     lat_c;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 32; r++) done[k][r] = 0;
                scnt[k] = 0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            thr = (k == 0 && id_branch) ? 0 : 1;
            exp_stall[k] = rst_n && id_valid && !id_flush &&
                           (model_hz(k, id_use_rs, id_rs, thr) || model_hz(k, id_use_rt, id_rt, thr));
        end
        chk("stall_br_id", longint'(stall0), longint'(exp_stall[0]));
        chk("stall_br_ex", longint'(stall1), longint'(exp_stall[1]));
        for (int k = 0; k < 2; k++) begin
            exp_busy = '0;
            for (int r = 1; r < 32; r++) exp_busy[r] = (done[k][r] > cyc);
            if (k == 0) chk("busy_br_id", longint'(busy0), longint'(exp_busy));
            else        chk("busy_br_ex", longint'(busy1), longint'(exp_busy));
        end
        chk("stall_cycles_br_id", longint'(sc0), scnt[0]);
        chk("stall_cycles_br_ex", longint'(sc1), scnt[1]);
        if (rst_n) begin
            lat_c = (int'(id_lat) > 3) ? 3 : int'(id_lat);
            for (int k = 0; k < 2; k++) begin
                if (id_valid && !id_flush && !exp_stall[k] && id_wr_en && id_wreg != 5'd0)
                    done[k][id_wreg] = cyc + lat_c + 1;
                if (exp_stall[k] && scnt[k] < 64'hFFFF_FFFF) scnt[k] = scnt[k] + 1;
            end
        end
        cyc++;
    endtask

    task automatic step(input stim_t s);
        @(negedge clk);
        rst_n     = s.rst_n;
        id_valid  = s.v;
        id_rs     = s.rs;
        id_rt     = s.rt;
        id_use_rs = s.urs;
        id_use_rt = s.urt;
        id_branch = s.br;
        id_wr_en  = s.we;
        id_wreg   = s.wr;
        id_lat    = s.lat;
        id_flush  = s.fl;
        #1;
        compare_and_advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(nop());
    endtask

    initial begin
        stim_t s;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) done[k][r] = 0;
            scnt[k] = 0;
        end
        rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0;
        id_use_rt = 1'b0; id_branch = 1'b0; id_wr_en = 1'b0; id_wreg = '0;
        id_lat = '0; id_flush = 1'b0;

        // Reset: hazard-shaped input must not stall.
        step(mk(0, 1, 7, 0, 1, 1, 1, 0, 0, 0, 0));
        chk("rst_stall", longint'(stall0), 0);
        chk("rst_busy", longint'(busy0), 0);
        chk("rst_sc", longint'(sc0), 0);
        idle(2);

        // Load r5 then dependent ALU: one bubble.
        step(mk(1, 1, 0, 0, 0, 0, 0, 1, 5, 2, 0));
        chk("ld_alu_t0", longint'(stall0), 0);
        step(mk(1, 1, 5, 1, 1, 1, 0, 1, 6, 1, 0));
        chk("ld_alu_t1", longint'(stall0), 1);
        chk("ld_alu_busy5", longint'(busy0[5]), 1);
        step(mk(1, 1, 5, 1, 1, 1, 0, 1, 6, 1, 0));
        chk("ld_alu_t2", longint'(stall0), 0);
        chk("ld_alu_sc", longint'(sc0), 1);
        idle(4);

        // ALU r3 then branch: one bubble in ID, none when branch is an EX consumer.
        step(mk(1, 1, 0, 0, 0, 0, 0, 1, 3, 1, 0));
        step(mk(1, 1, 3, 4, 1, 1, 1, 0, 0, 0, 0));
        chk("alu_br_id_t1", longint'(stall0), 1);
        chk("alu_br_ex_t1", longint'(stall1), 0);
        step(mk(1, 1, 3, 4, 1, 1, 1, 0, 0, 0, 0));
        chk("alu_br_id_t2", longint'(stall0), 0);
        idle(4);

        // Load r7 then beq r7,r0: two bubbles in ID.
        step(mk(1, 1, 0, 0, 0, 0, 0, 1, 7, 2, 0));
        step(mk(1, 1, 7, 0, 1, 1, 1, 0, 0, 0, 0));
        chk("ld_br_t1", longint'(stall0), 1);
        chk("ld_br_ex_t1", longint'(stall1), 1);
        step(mk(1, 1, 7, 0, 1, 1, 1, 0, 0, 0, 0));
        chk("ld_br_t2", longint'(stall0), 1);
        chk("ld_br_ex_t2", longint'(stall1), 0);
        step(mk(1, 1, 7, 0, 1, 1, 1, 0, 0, 0, 0));
        chk("ld_br_t3", longint'(stall0), 0);
        // r0 is never tracked, even after a write aimed at it.
        step(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 3, 0));
        step(mk(1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        chk("r0_stall", longint'(stall0), 0);
        chk("r0_busy", longint'(busy0[0]), 0);
        idle(4);

        // Overwrite: lat-3 then lat-1 to r9; ALU consumer two cycles later is free.
        step(mk(1, 1, 0, 0, 0, 0, 0, 1, 9, 3, 0));
        step(mk(1, 1, 0, 0, 0, 0, 0, 1, 9, 1, 0));
        step(mk(1, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0));
        chk("ovw_stall", longint'(stall0), 0);
        chk("ovw_busy9", longint'(busy0[9]), 1);
        step(nop());
        chk("ovw_busy9_drained", longint'(busy0[9]), 0);
        idle(4);

        // Flushed dependent: no stall, no write of r6.
        step(mk(1, 1, 0, 0, 0, 0, 0, 1, 5, 2, 0));
        step(mk(1, 1, 5, 1, 1, 1, 0, 1, 6, 3, 1));
        chk("flush_stall", longint'(stall0), 0);
        step(nop());
        chk("flush_busy6", longint'(busy0[6]), 0);
        chk("flush_busy5", longint'(busy0[5]), 1);
        step(nop());
        chk("flush_busy5_drained", longint'(busy0[5]), 0);
        idle(4);

        // Reset in the middle of a branch stall.
        step(mk(1, 1, 0, 0, 0, 0, 0, 1, 7, 2, 0));
        step(mk(1, 1, 7, 0, 1, 1, 1, 0, 0, 0, 0));
        chk("rst_mid_stall_before", longint'(stall0), 1);
        step(mk(0, 1, 7, 0, 1, 1, 1, 0, 0, 0, 0));
        chk("rst_mid_stall", longint'(stall0), 0);
        chk("rst_mid_busy", longint'(busy0), 0);
        chk("rst_mid_sc", longint'(sc0), 0);
        step(mk(1, 1, 7, 0, 1, 1, 1, 0, 0, 0, 0));
        chk("rst_rel_stall", longint'(stall0), 0);
        chk("rst_rel_sc", longint'(sc0), 0);
        idle(4);

        // Randomized traffic on a narrow register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            s = mk(($urandom_range(0, 499) == 0) ? 0 : 1,
                   ($urandom_range(0, 9) != 0) ? 1 : 0,
                   $urandom_range(0, 11), $urandom_range(0, 11),
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   ($urandom_range(0, 9) < 3) ? 1 : 0,
                   $urandom_range(0, 1), $urandom_range(0, 11),
                   $urandom_range(0, 3),
                   ($urandom_range(0, 9) == 0) ? 1 : 0);
            step(s);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised, scoreboard-based interlock unit for the in-order MIPS pipeline. It generalises the fixed load-use and branch-compare checks into one per-register countdown table: each producer declares how many cycles until its result can be forwarded, and consumers in ID stall until their operands are reachable. It sits beside the ID stage. Its `stall` output freezes PC/IF-ID and inserts a bubble into ID/EX.

## Interface
- `NREG`, 32: architectural register count; register 0 is hard-wired zero and is never tracked.
- `AW`, 5: register index width, equal to log2(NREG).
- `MAX_LAT`, 3: largest accepted producer latency.
- `LW`, 2: counter width; must satisfy 2^LW > MAX_LAT.
- `BR_IN_ID`, 1: 1 means branches compare in ID and need a distance-0 operand; 0 means branches are treated as ordinary EX consumers.
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `id_valid`, in, 1: ID holds a real instruction.
- `id_rs`, in, AW: source index 1.
- `id_rt`, in, AW: source index 2.
- `id_use_rs`, in, 1: instruction reads rs.
- `id_use_rt`, in, 1: instruction reads rt.
- `id_branch`, in, 1: instruction is a branch or compare consumer.
- `id_wr_en`, in, 1: instruction writes a register.
- `id_wreg`, in, AW: destination index.
- `id_lat`, in, LW: producer latency. ALU = 1, load = 2, multi-cycle unit = up to MAX_LAT.
- `id_flush`, in, 1: squash the ID instruction this cycle.
- `stall`, out, 1: combinational hold request.
- `busy`, out, NREG: registered; bit i = (cnt[i] != 0).
- `stall_cycles`, out, 32: registered count of stall cycles, saturating at 0xFFFFFFFF.

## Operation
- State: `cnt[i]`, LW bits, for i = 1..NREG-1. `cnt[0]` is constant 0.
- Issue condition: `issue = id_valid & ~id_flush & ~stall`.
- Per-source hazard: `hz_rs = id_use_rs & (id_rs != 0) & (cnt[id_rs] > thr)`. `hz_rt` is formed the same way.
- Threshold: `thr` = 0 when `BR_IN_ID & id_branch`; otherwise `thr` = 1, which covers EX-to-EX forwarding.
- Stall: `stall = id_valid & ~id_flush & (hz_rs | hz_rt)`.
- Counter update each cycle, for every i:
  - if `issue & id_wr_en & (id_wreg == i) & (i != 0)`: `cnt[i] <= min(id_lat, MAX_LAT)`. The newer producer overwrites, even if the old count was larger or smaller.
  - else if `cnt[i] != 0`: `cnt[i] <= cnt[i] - 1`.
  - else hold at 0.
- `id_lat` = 0 writes 0, meaning no tracking.
- Stalled instructions never update the table. They re-evaluate every cycle until released.
- `id_flush` suppresses both stall and issue. Older in-flight producers keep counting down; the flush does not clear them.
- `stall_cycles` increments on every cycle where `stall` = 1.

## Timing
- Reset (`rst_n` low, asynchronous): all `cnt` = 0, `busy` = 0, `stall_cycles` = 0. `stall` is then 0 for any input.
- Releasing reset mid-stall: the table is empty, so the held ID instruction issues on the first clock after release.
- `stall` has zero latency: it is combinational from ID inputs and current counters.
- Producer issued at cycle t: `cnt` = lat in cycle t+1, then decrements by 1 per cycle down to 0.
- Resulting bubbles for a dependent instruction that reaches ID at t+1:
  - ALU to ALU: 0 bubbles.
  - load to ALU: 1 bubble.
  - ALU to branch: 1 bubble.
  - load to branch: 2 bubbles.
  - lat-3 producer to ALU: 2 bubbles.
- If the same register is both a producer destination and a consumer source in one instruction, the check uses the old count. The new count is written only if the instruction issues.

## Test plan
- Load r5 (lat 2) at t, then `add r6,r5,r1` in ID at t+1 -> stall = 1 at t+1, 0 at t+2; `stall_cycles` = 1.
- ALU r3 (lat 1) at t, then `beq r3,r4` at t+1 with BR_IN_ID = 1 -> exactly 1 stall cycle. Repeat with BR_IN_ID = 0 -> 0 stalls.
- Load r7 at t, then `beq r7,r0` at t+1 -> stall at t+1 and t+2, release at t+3. Reading r0 alone never stalls.
- Lat-3 write to r9 at t, then lat-1 write to r9 at t+1 -> cnt[9] = 1 at t+2 (overwrite). Consumer of r9 at t+2 does not stall.
- Dependent instruction stalled with `id_flush` = 1 -> stall = 0, no table update, `busy` unchanged apart from countdown.
- Assert `rst_n` low during a 2-cycle branch stall -> `busy` = 0, `stall_cycles` = 0, stall deasserts immediately; after release the counters start from 0.
